// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    RESYNC
  } rx_state_t;

endpackage

// File: rtl/uart_rx_out_buf.sv
// One-entry valid/ready holding register for a received word and its error flags.
// A word arriving while the register is full and not being drained is dropped
// and reported with a one-cycle overrun pulse.
module uart_rx_out_buf
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_perr,
  input  logic                  in_ferr,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  // Load when empty or draining this cycle; otherwise drop and flag overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (in_valid) begin
      if (!valid_q || out_ready) begin
        data_d  = in_data;
        perr_d  = in_perr;
        ferr_d  = in_ferr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART frame receiver, one line bit per clock: start, LSB-first data, parity
// (whole-frame or after every byte, even over all data bits so far), stop.
// Optional macro UART_RX_SYNC_EN: pass rx_in through a 2-flop synchronizer.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  parity_per_byte,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  rx_busy
);

  localparam int BIT_CW    = $clog2(DATA_WIDTH + 1);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_BITS;
  localparam int BYTE_CW   = $clog2(NUM_BYTES + 1);

  generate
    if ((DATA_WIDTH % BYTE_BITS) != 0 || DATA_WIDTH == 0) begin : g_bad_width
      $error("uart_rx_deframer: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-stage synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx = sync2_q;
`else
  assign rx = rx_in;
`endif

  rx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BYTE_CW-1:0]    byte_cnt_q, byte_cnt_d;
  logic                  run_par_q, run_par_d;
  logic                  err_q, err_d;
  logic                  pb_mode_q, pb_mode_d;
  logic                  dlv_q, dlv_d;
  logic                  dlv_ferr_q, dlv_ferr_d;

  // Next-state logic: deframing, running parity and the delivery strobe.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    run_par_d  = run_par_q;
    err_d      = err_q;
    pb_mode_d  = pb_mode_q;
    dlv_d      = 1'b0;
    dlv_ferr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d    = DATA;
          pb_mode_d  = parity_per_byte;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          run_par_d  = 1'b0;
          err_d      = 1'b0;
        end
      end
      DATA: begin
        shreg_d   = {rx, shreg_q[DATA_WIDTH-1:1]};
        run_par_d = run_par_q ^ rx;
        bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        if (pb_mode_q ? (bit_cnt_q[2:0] == 3'd7)
                      : (bit_cnt_q == BIT_CW'(DATA_WIDTH - 1))) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        if (rx != run_par_q) begin
          err_d = 1'b1;
        end
        byte_cnt_d = byte_cnt_q + BYTE_CW'(1);
        if (pb_mode_q && (byte_cnt_d != BYTE_CW'(NUM_BYTES))) begin
          state_d = DATA;
        end else begin
          state_d = STOP;
        end
      end
      STOP: begin
        // The frame is handed over whether or not the stop bit is good.
        dlv_d      = 1'b1;
        dlv_ferr_d = !rx;
        state_d    = rx ? IDLE : RESYNC;
      end
      RESYNC: begin
        // Wait out a stuck-low line so it is not read as a start bit.
        if (rx) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      run_par_q  <= 1'b0;
      err_q      <= 1'b0;
      pb_mode_q  <= 1'b0;
      dlv_q      <= 1'b0;
      dlv_ferr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      run_par_q  <= run_par_d;
      err_q      <= err_d;
      pb_mode_q  <= pb_mode_d;
      dlv_q      <= dlv_d;
      dlv_ferr_q <= dlv_ferr_d;
    end
  end

  assign rx_busy = (state_q != IDLE);

  // shreg_q and err_q are untouched during the cycle after STOP (IDLE only
  // clears err on its way out), so the buffer still sees the finished frame.
  uart_rx_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (dlv_q),
    .in_data   (shreg_q),
    .in_perr   (err_q),
    .in_ferr   (dlv_ferr_q),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

endmodule
